multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Purpose : groups the opcode/flag inputs and the datapath control outputs of multicycle_control.
// Latency : n/a (wires only).
// Backpressure: memReady is the only stall signal; the controller holds a memory state while it is low.
// Ports   : opCode[5:0], zero, memReady   -> controller
//           pcWrite, irWrite, memRead, memWrite, iOrD, aluSrcA, regDst, memToReg, regWrite,
//           aluSrcB[1:0], aluOp[1:0], pcSource[1:0], state[3:0], trap  <- controller
// Modports: master = the controller, slave = the datapath it steers.
interface multicycle_control_if;
    logic [5:0] opCode;
    logic       zero;
    logic       memReady;

    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       aluSrcA;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic [3:0] state;
    logic       trap;

    modport master (
        input  opCode, zero, memReady,
        output pcWrite, irWrite, memRead, memWrite, iOrD, aluSrcA, regDst,
               memToReg, regWrite, aluSrcB, aluOp, pcSource, state, trap
    );

    modport slave (
        output opCode, zero, memReady,
        input  pcWrite, irWrite, memRead, memWrite, iOrD, aluSrcA, regDst,
               memToReg, regWrite, aluSrcB, aluOp, pcSource, state, trap
    );
endinterface

// File: rtl/multicycle_control.sv
// Purpose : Moore control FSM for a multicycle MIPS-style datapath (fetch/decode/execute/memory/writeback).
// Latency : R 4, LW 5, SW 4, BEQ/BNE 3, J 3, ADDI 4 cycles with memReady high; +1 per low memReady cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold while memReady is low; nothing else waits.
// Ports   : clock, reset (async, active-high) and bus (multicycle_control_if.master).
// Config  : define MULTICYCLE_CONTROL_TRAP_EN to send unknown opcodes to a sticky TRAP state;
//           otherwise unknown opcodes behave as a NOP and trap stays 0.
module multicycle_control (
    input  logic                        clock,
    input  logic                        reset,
    multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.state = state_q;

    // Next state and Moore outputs. All enables are forced low while reset is
    // held so that FETCH's memRead/irWrite/pcWrite cannot leak out during reset.
    always_comb begin
        state_d      = state_q;
        bus.pcWrite  = 1'b0;
        bus.irWrite  = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.iOrD     = 1'b0;
        bus.aluSrcA  = 1'b0;
        bus.regDst   = 1'b0;
        bus.memToReg = 1'b0;
        bus.regWrite = 1'b0;
        bus.aluSrcB  = 2'b00;
        bus.aluOp    = 2'b00;
        bus.pcSource = 2'b00;
        bus.trap     = 1'b0;

        case (state_q)
            FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = 2'b01;
                // IR and PC+4 are captured only on the cycle the read completes.
                bus.irWrite = bus.memReady;
                bus.pcWrite = bus.memReady;
                if (bus.memReady) begin
                    state_d = DECODE;
                end
            end

            DECODE: begin
                // Branch target is precomputed here from the shifted immediate.
                bus.aluSrcB = 2'b11;
                case (bus.opCode)
                    OP_RTYPE:      state_d = EXEC;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:          state_d = JUMP;
                    OP_ADDI:       state_d = ADDI_EX;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    default:       state_d = TRAP;
`else
                    default:       state_d = FETCH;
`endif
                endcase
            end

            MEMADR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_d     = (bus.opCode == OP_SW) ? MEMWR : MEMRD;
            end

            MEMRD: begin
                bus.memRead = 1'b1;
                bus.iOrD    = 1'b1;
                if (bus.memReady) begin
                    state_d = MEMWB;
                end
            end

            MEMWB: begin
                bus.memToReg = 1'b1;
                bus.regWrite = 1'b1;
                state_d      = FETCH;
            end

            MEMWR: begin
                bus.memWrite = 1'b1;
                bus.iOrD     = 1'b1;
                if (bus.memReady) begin
                    state_d = FETCH;
                end
            end

            EXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b10;
                state_d     = RWB;
            end

            RWB: begin
                bus.regDst   = 1'b1;
                bus.regWrite = 1'b1;
                state_d      = FETCH;
            end

            BRANCH: begin
                bus.aluSrcA  = 1'b1;
                bus.aluOp    = 2'b01;
                bus.pcSource = 2'b01;
                bus.pcWrite  = ((bus.opCode == OP_BEQ) &&  bus.zero) ||
                               ((bus.opCode == OP_BNE) && !bus.zero);
                state_d      = FETCH;
            end

            JUMP: begin
                bus.pcSource = 2'b10;
                bus.pcWrite  = 1'b1;
                state_d      = FETCH;
            end

            ADDI_EX: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_d     = ADDI_WB;
            end

            ADDI_WB: begin
                bus.regWrite = 1'b1;
                state_d      = FETCH;
            end

            TRAP: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                // Sticky until reset; every datapath enable stays low.
                bus.trap = 1'b1;
                state_d  = TRAP;
`else
                state_d  = FETCH;
`endif
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        if (reset) begin
            bus.pcWrite  = 1'b0;
            bus.irWrite  = 1'b0;
            bus.memRead  = 1'b0;
            bus.memWrite = 1'b0;
            bus.iOrD     = 1'b0;
            bus.aluSrcA  = 1'b0;
            bus.regDst   = 1'b0;
            bus.memToReg = 1'b0;
            bus.regWrite = 1'b0;
            bus.aluSrcB  = 2'b00;
            bus.aluOp    = 2'b00;
            bus.pcSource = 2'b00;
            bus.trap     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : self-checking bench for multicycle_control; randomized instruction stream and stalls
//           compared cycle by cycle against an instruction-level reference model.
// Ports   : none (instantiates multicycle_control_if and the DUT).
// Config  : honours MULTICYCLE_CONTROL_TRAP_EN the same way as the design.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int vec_cnt = 0;
    int err_cnt = 0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, need $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control outputs for one cycle, as a table of what each phase drives.
    // Bit order: pcWrite irWrite memRead memWrite iOrD aluSrcA regDst memToReg regWrite
    //            aluSrcB[1:0] aluOp[1:0] pcSource[1:0]
    function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] op,
                                             input logic z, input logic mr);
        logic pw, iw, mrd, mw, iod, asa, rd, m2r, rw;
        logic [1:0] asb, aop, pcs;
        {pw, iw, mrd, mw, iod, asa, rd, m2r, rw} = 9'b0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; iw = mr; pw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01;
                      pw = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z); end
            9:  begin pcs = 2'b10; pw = 1; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, iw, mrd, mw, iod, asa, rd, m2r, rw, asb, aop, pcs};
    endfunction

    function automatic logic [14:0] dut_ctrl();
        return {bus.pcWrite, bus.irWrite, bus.memRead, bus.memWrite, bus.iOrD, bus.aluSrcA,
                bus.regDst, bus.memToReg, bus.regWrite, bus.aluSrcB, bus.aluOp, bus.pcSource};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
    endfunction

    // Instruction-level model: the sequence of phases an opcode walks through.
    task automatic build_path(input logic [5:0] op, output int path[$]);
        path = {0, 1};
        case (op)
            OP_R:           path = {0, 1, 6, 7};
            OP_LW:          path = {0, 1, 2, 3, 4};
            OP_SW:          path = {0, 1, 2, 5};
            OP_BEQ, OP_BNE: path = {0, 1, 8};
            OP_J:           path = {0, 1, 9};
            OP_ADDI:        path = {0, 1, 10, 11};
            default: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                path = {0, 1, 12};
`else
                path = {0, 1};
`endif
            end
        endcase
    endtask

    // stall_mode: 0 memReady high, 1 random, 2 low for 3 cycles in MEMRD/MEMWR.
    // zmode: 0 random zero, 1 zero=0, 2 zero=1.
    task automatic run_instr(input logic [5:0] op, input int stall_mode, input int zmode);
        int path[$];
        int idx, cur, stall_run, mw_cnt, hold, guard;
        build_path(op, path);
        idx = 0; cur = 0; stall_run = 0; mw_cnt = 0; hold = 0; guard = 0;
        while (idx < path.size() && guard < 200) begin
            @(negedge clock);
            guard++;
            cur = path[idx];
            bus.opCode = op;
            case (stall_mode)
                0:       bus.memReady = 1'b1;
                1:       bus.memReady = ($urandom_range(0, 3) != 0);
                default: bus.memReady = ((cur == 3 || cur == 5) && stall_run < 3) ? 1'b0 : 1'b1;
            endcase
            case (zmode)
                1:       bus.zero = 1'b0;
                2:       bus.zero = 1'b1;
                default: bus.zero = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("state", 32'(bus.state), 32'(cur));
            chk("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(cur, op, bus.zero, bus.memReady)));
            chk("trap", 32'(bus.trap), 32'(cur == 12));
            chk("wr_excl", 32'(bus.memWrite & bus.regWrite), 32'd0);
            if (bus.memWrite) mw_cnt++;
            if (cur == 12) begin
                hold++;
                if (hold == 4) idx = path.size();
            end else if ((cur == 0 || cur == 3 || cur == 5) && !bus.memReady) begin
                stall_run++;
            end else begin
                idx++;
                stall_run = 0;
            end
        end
        if (guard >= 200) begin
            err_cnt++;
            $display("FAIL instr_budget: op 0x%0h did not finish within 200 cycles", op);
        end
        if (stall_mode == 2 && op == OP_SW) chk("sw_mw_run", 32'(mw_cnt), 32'd4);
        if (cur == 12) begin
            @(negedge clock);
            reset = 1'b1;
            bus.memReady = 1'b0;
            #1;
            chk("trap_rst_state", 32'(bus.state), 32'd0);
            chk("trap_rst_trap", 32'(bus.trap), 32'd0);
            @(negedge clock);
            reset = 1'b0;
        end
    endtask

    task automatic reset_mid_memrd();
        int seq[3] = '{0, 1, 2};
        bus.opCode = OP_LW;
        bus.zero   = 1'b0;
        foreach (seq[i]) begin
            @(negedge clock);
            bus.memReady = 1'b1;
            #1;
            chk("rst_pre_state", 32'(bus.state), 32'(seq[i]));
        end
        @(negedge clock);
        bus.memReady = 1'b0;
        #1;
        chk("rst_memrd_state", 32'(bus.state), 32'd3);
        chk("rst_memrd_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(3, OP_LW, 1'b0, 1'b0)));
        #2;
        reset = 1'b1;
        bus.memReady = 1'b1;
        #1;
        chk("rst_async_state", 32'(bus.state), 32'd0);
        chk("rst_async_ctrl", 32'(dut_ctrl()), 32'd0);
        @(negedge clock);
        #1;
        chk("rst_hold_state", 32'(bus.state), 32'd0);
        chk("rst_hold_ctrl", 32'(dut_ctrl()), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        bus.memReady = 1'b0;
        #1;
        chk("rst_rel_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, OP_LW, 1'b0, 1'b0)));
        @(negedge clock);
        #1;
        chk("rst_fetch_state", 32'(bus.state), 32'd0);
        chk("rst_fetch_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, OP_LW, 1'b0, 1'b0)));
    endtask

    initial begin
        logic [5:0] legal [7];
        logic [5:0] op;
        legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
        bus.opCode   = OP_R;
        bus.zero     = 1'b0;
        bus.memReady = 1'b1;
        reset        = 1'b1;

        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_ctrl", 32'(dut_ctrl()), 32'd0);
        chk("reset_trap", 32'(bus.trap), 32'd0);
        bus.memReady = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        reset_mid_memrd();

        run_instr(OP_LW,   0, 0);
        run_instr(OP_SW,   2, 0);
        run_instr(OP_LW,   2, 0);
        run_instr(OP_BNE,  0, 2);
        run_instr(OP_BNE,  0, 1);
        run_instr(OP_BEQ,  0, 2);
        run_instr(OP_BEQ,  0, 1);
        run_instr(OP_R,    0, 0);
        run_instr(OP_J,    0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_ADDI, 0, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) < 7) begin
                op = legal[$urandom_range(0, 6)];
            end else begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end
            run_instr(op, ($urandom_range(0, 1) == 0) ? 0 : 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
